rwt_tag_extract: RTL and testbench

- Receive-side counterpart of the tag-insertion path: consumes an escaped AXI-stream word stream and strips the escape words.
- Restores literal data words that were equal to tag_escape.
- Decodes in-band tag words into sideband tag_valid/tag_type, with the tag value in the low bits of data.
- Sits after the transport/DMA input and before the consumer; uses the same escape value and tag word layout as the inserter.

---
 rtl/rwt_tag_pkg.sv | 26 ++
 rtl/rwt_tag_extract_outreg.sv | 44 ++++
 rtl/rwt_tag_extract.sv | 127 ++++++++++++
 tb/tb_rwt_tag_extract.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rwt_tag_pkg.sv
// Field layout, FSM encoding and reserved codes for the in-band tag format.
// The tag inserter uses the same definitions.
package rwt_tag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ESC   = 2'd1,
    ST_CHAIN = 2'd2
  } tag_state_e;

  // Tag type 0, value 0, MORE 0 after an escape means "literal escape word".
  localparam int LIT_ESC_CODE = 0;

  function automatic int tag_width(input int dwidth, input int type_width);
    return dwidth - 1 - type_width;
  endfunction

  function automatic int more_bit(input int dwidth);
    return dwidth - 1;
  endfunction

  function automatic int type_lsb(input int dwidth, input int type_width);
    return tag_width(dwidth, type_width);
  endfunction

endpackage

// File: rtl/rwt_tag_extract_outreg.sv
// Single register slice for the decoded output item {data, tag_valid, tag_type, last}.
// A load without emit consumes an input word but leaves the slice empty.
module rwt_tag_extract_outreg #(
  parameter int DWIDTH     = 64,
  parameter int TYPE_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  emit,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic                  in_tag_valid,
  input  logic [TYPE_WIDTH-1:0] in_tag_type,
  input  logic                  in_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DWIDTH-1:0]     out_data,
  output logic                  out_tag_valid,
  output logic [TYPE_WIDTH-1:0] out_tag_type,
  output logic                  out_last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_tag_valid <= 1'b0;
      out_tag_type  <= '0;
      out_last      <= 1'b0;
    end else if (load) begin
      out_valid <= emit;
      // Payload only changes on an emitting load, so it holds while stalled.
      if (emit) begin
        out_data      <= in_data;
        out_tag_valid <= in_tag_valid;
        out_tag_type  <= in_tag_type;
        out_last      <= in_last;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rwt_tag_extract.sv
// Strips escape words from an escaped stream, restores literal escape words and
// decodes in-band tag words into sideband tag_valid/tag_type.
module rwt_tag_extract
  import rwt_tag_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int TYPE_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  use_tags,
  input  logic [DWIDTH-1:0]     tag_escape,
  output logic                  s_axi_ready,
  input  logic                  s_axi_valid,
  input  logic [DWIDTH-1:0]     s_axi_data,
  input  logic                  s_axi_last,
  input  logic                  m_axi_ready,
  output logic                  m_axi_valid,
  output logic [DWIDTH-1:0]     m_axi_data,
  output logic                  m_axi_tag_valid,
  output logic [TYPE_WIDTH-1:0] m_axi_tag_type,
  output logic                  m_axi_last,
  output logic                  protocol_error
);

  localparam int TAG_WIDTH = tag_width(DWIDTH, TYPE_WIDTH);
  localparam int MORE_BIT  = more_bit(DWIDTH);
  localparam int TYPE_LSB  = type_lsb(DWIDTH, TYPE_WIDTH);

  tag_state_e state_reg, state_next;
  logic       accept;
  logic       word_is_esc, word_is_lit, take_tag, err_next;
  logic       emit_next, tag_valid_next, last_next;
  logic [DWIDTH-1:0]     data_next;
  logic [TYPE_WIDTH-1:0] tag_type_next;
  logic                  field_more;
  logic [TYPE_WIDTH-1:0] field_type;
  logic [TAG_WIDTH-1:0]  field_value;

  assign s_axi_ready = ~m_axi_valid | m_axi_ready;
  assign accept      = s_axi_valid & s_axi_ready;

  assign word_is_esc = (s_axi_data == tag_escape);
  assign word_is_lit = (s_axi_data == DWIDTH'(LIT_ESC_CODE));
  assign field_more  = s_axi_data[MORE_BIT];
  assign field_type  = s_axi_data[TYPE_LSB +: TYPE_WIDTH];
  assign field_value = s_axi_data[0 +: TAG_WIDTH];

  always_comb begin
    emit_next      = 1'b1;
    data_next      = s_axi_data;
    tag_valid_next = 1'b0;
    tag_type_next  = '0;
    last_next      = s_axi_last;
    state_next     = state_reg;
    err_next       = 1'b0;
    take_tag       = 1'b0;
    if (!use_tags) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (word_is_esc) begin
            emit_next = 1'b0;
            // An escape cannot end a packet: nothing follows to complete it.
            if (s_axi_last) err_next = 1'b1;
            else            state_next = ST_ESC;
          end
        end
        ST_ESC: begin
          if (word_is_lit) begin
            data_next  = tag_escape;
            state_next = ST_IDLE;
          end else begin
            take_tag = 1'b1;
          end
        end
        ST_CHAIN: take_tag = 1'b1;
        default:  state_next = ST_IDLE;
      endcase
      if (take_tag) begin
        data_next      = DWIDTH'(field_value);
        tag_valid_next = 1'b1;
        tag_type_next  = field_type;
        if (field_more && !s_axi_last) begin
          last_next  = 1'b0;
          state_next = ST_CHAIN;
        end else begin
          // A chain cut short by packet end still delivers its last tag.
          err_next   = field_more;
          state_next = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      protocol_error <= 1'b0;
    end else begin
      protocol_error <= accept & err_next;
      if (accept || !use_tags) state_reg <= state_next;
    end
  end

  rwt_tag_extract_outreg #(
    .DWIDTH     (DWIDTH),
    .TYPE_WIDTH (TYPE_WIDTH)
  ) u_outreg (
    .clk           (clk),
    .reset         (reset),
    .load          (accept),
    .emit          (emit_next),
    .in_data       (data_next),
    .in_tag_valid  (tag_valid_next),
    .in_tag_type   (tag_type_next),
    .in_last       (last_next),
    .out_ready     (m_axi_ready),
    .out_valid     (m_axi_valid),
    .out_data      (m_axi_data),
    .out_tag_valid (m_axi_tag_valid),
    .out_tag_type  (m_axi_tag_type),
    .out_last      (m_axi_last)
  );

endmodule

// File: tb/tb_rwt_tag_extract.sv
// Directed and randomised-ready checks for rwt_tag_extract with a queue scoreboard.
module tb_rwt_tag_extract;

  localparam logic [63:0] ESC = 64'hDEAD_BEEF_CAFE_F00D;

  typedef struct packed {
    logic [63:0] data;
    logic        tv;
    logic [6:0]  ty;
    logic        last;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        use_tags;
  logic [63:0] tag_escape;
  logic        s_axi_ready;
  logic        s_axi_valid;
  logic [63:0] s_axi_data;
  logic        s_axi_last;
  logic        m_axi_ready;
  logic        m_axi_valid;
  logic [63:0] m_axi_data;
  logic        m_axi_tag_valid;
  logic [6:0]  m_axi_tag_type;
  logic        m_axi_last;
  logic        protocol_error;

  item_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    err_seen = 0;
  int    err_exp = 0;
  bit    rand_ready = 1'b0;

  always #5 clk = ~clk;

  rwt_tag_extract #(.DWIDTH(64), .TYPE_WIDTH(7)) dut (
    .clk             (clk),
    .reset           (reset),
    .use_tags        (use_tags),
    .tag_escape      (tag_escape),
    .s_axi_ready     (s_axi_ready),
    .s_axi_valid     (s_axi_valid),
    .s_axi_data      (s_axi_data),
    .s_axi_last      (s_axi_last),
    .m_axi_ready     (m_axi_ready),
    .m_axi_valid     (m_axi_valid),
    .m_axi_data      (m_axi_data),
    .m_axi_tag_valid (m_axi_tag_valid),
    .m_axi_tag_type  (m_axi_tag_type),
    .m_axi_last      (m_axi_last),
    .protocol_error  (protocol_error)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic tv, input logic [6:0] ty, input logic l);
    item_t it;
    it.data = d; it.tv = tv; it.ty = ty; it.last = l;
    exp_q.push_back(it);
  endtask

  // Entered and left at posedge+1; each accepted word takes exactly one cycle.
  task automatic send(input logic [63:0] d, input logic l);
    int n;
    s_axi_valid = 1'b1;
    s_axi_data  = d;
    s_axi_last  = l;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (s_axi_ready) break;
      @(posedge clk);
      n++;
    end
    if (n >= 1000) begin
      tests++; fails++;
      $display("[TB] FAIL send_timeout got=stalled exp=accept");
    end
    @(posedge clk); #1;
    s_axi_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_axi_valid) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++; fails++;
      $display("[TB] FAIL drain_timeout got=%0d exp=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    m_axi_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axi_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on each handshake, checks payload stability while stalled.
  initial begin
    item_t exp_it, held;
    bit    hold_pending = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("stall_valid", 64'(m_axi_valid), 64'd1);
          check("stall_payload_data", m_axi_data, held.data);
          check("stall_payload_side", 64'({m_axi_tag_valid, m_axi_tag_type, m_axi_last}),
                64'({held.tv, held.ty, held.last}));
        end
        if (m_axi_valid && m_axi_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL unexpected_output got=%h exp=none", m_axi_data);
          end else begin
            exp_it = exp_q.pop_front();
            $display("[TB] out data=%h tv=%0d type=%h last=%0d", m_axi_data, m_axi_tag_valid,
                     m_axi_tag_type, m_axi_last);
            check("out_data", m_axi_data, exp_it.data);
            check("out_side", 64'({m_axi_tag_valid, m_axi_tag_type, m_axi_last}),
                  64'({exp_it.tv, exp_it.ty, exp_it.last}));
          end
        end
        hold_pending = m_axi_valid && !m_axi_ready;
        held = {m_axi_data, m_axi_tag_valid, m_axi_tag_type, m_axi_last};
        if (protocol_error) err_seen++;
      end
    end
  end

  task automatic gen_random();
    int          words = 0;
    int          k, n;
    logic [63:0] d, v;
    logic [6:0]  ty;
    logic        l, more;
    while (words < 1000) begin
      k = $urandom_range(0, 2);
      l = ($urandom_range(0, 7) == 0);
      if (k == 0) begin
        d = {$urandom, $urandom};
        if (d == ESC) d = d ^ 64'h1;
        push(d, 1'b0, 7'h0, l);
        send(d, l);
        words += 1;
      end else if (k == 1) begin
        push(ESC, 1'b0, 7'h0, l);
        send(ESC, 1'b0);
        send(64'h0, l);
        words += 2;
      end else begin
        n = $urandom_range(1, 3);
        send(ESC, 1'b0);
        words += 1;
        for (int j = 0; j < n; j++) begin
          more = (j < n - 1);
          ty   = 7'($urandom_range(1, 127));
          v    = {$urandom, $urandom};
          push({8'h00, v[55:0]}, 1'b1, ty, more ? 1'b0 : l);
          send({more, ty, v[55:0]}, more ? 1'b0 : l);
          words += 1;
        end
      end
    end
  endtask

  initial begin
    longint t0;
    reset = 1'b1; use_tags = 1'b1; tag_escape = ESC;
    s_axi_valid = 1'b0; s_axi_data = '0; s_axi_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(m_axi_valid), 64'd0);
    check("rst_data", m_axi_data, 64'd0);
    check("rst_tag_valid", 64'(m_axi_tag_valid), 64'd0);
    check("rst_tag_type", 64'(m_axi_tag_type), 64'd0);
    check("rst_last", 64'(m_axi_last), 64'd0);
    check("rst_perr", 64'(protocol_error), 64'd0);
    @(posedge clk); #1;

    // Plain data with one-cycle latency
    push(64'h1, 1'b0, 7'h0, 1'b0);
    send(64'h1, 1'b0);
    @(negedge clk);
    check("latency_valid", 64'(m_axi_valid), 64'd1);
    check("latency_data", m_axi_data, 64'h1);
    @(posedge clk); #1;
    push(64'h2, 1'b0, 7'h0, 1'b1);
    send(64'h2, 1'b1);
    drain();

    // Escaped literal
    push(ESC, 1'b0, 7'h0, 1'b1);
    send(ESC, 1'b0);
    send(64'h0, 1'b1);
    drain();

    // Two-tag chain then data, at full throughput
    push(64'h42, 1'b1, 7'h5, 1'b0);
    push(64'h7, 1'b1, 7'h3, 1'b0);
    push(64'h5, 1'b0, 7'h0, 1'b1);
    t0 = $time;
    send(ESC, 1'b0);
    send(64'h8500_0000_0000_0042, 1'b0);
    send(64'h0300_0000_0000_0007, 1'b0);
    send(64'h5, 1'b1);
    check("throughput_cycles", 64'(($time - t0) / 10), 64'd4);
    drain();

    // Escape value inside a chain is a tag
    push(64'h1, 1'b1, 7'h1, 1'b0);
    push(64'h00AD_BEEF_CAFE_F00D, 1'b1, 7'h5E, 1'b0);
    push(64'h3, 1'b1, 7'h2, 1'b1);
    send(ESC, 1'b0);
    send(64'h8100_0000_0000_0001, 1'b0);
    send(ESC, 1'b0);
    send(64'h0200_0000_0000_0003, 1'b1);
    drain();

    // Escape with last: error, no output
    err_exp++;
    send(ESC, 1'b1);
    drain();
    check("perr_esc_last", 64'(err_seen), 64'(err_exp));

    // Chain cut by last: tag delivered with last, error
    err_exp++;
    push(64'h11, 1'b1, 7'h4, 1'b1);
    push(64'h77, 1'b0, 7'h0, 1'b1);
    send(ESC, 1'b0);
    send(64'h8400_0000_0000_0011, 1'b1);
    send(64'h77, 1'b1);
    drain();
    check("perr_chain_last", 64'(err_seen), 64'(err_exp));

    // Pass-through
    use_tags = 1'b0;
    push(ESC, 1'b0, 7'h0, 1'b0);
    push(64'h0, 1'b0, 7'h0, 1'b1);
    send(ESC, 1'b0);
    send(64'h0, 1'b1);
    drain();
    use_tags = 1'b1;

    // Mixed traffic under random backpressure
    rand_ready = 1'b1;
    gen_random();
    rand_ready = 1'b0;
    drain();

    // Reset in the middle of a chain
    push(64'h1, 1'b1, 7'h1, 1'b0);
    send(ESC, 1'b0);
    send(64'h8100_0000_0000_0001, 1'b0);
    drain();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 64'(m_axi_valid), 64'd0);
    check("midrst_data", m_axi_data, 64'd0);
    check("midrst_side", 64'({m_axi_tag_valid, m_axi_tag_type, m_axi_last}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push(64'h9, 1'b0, 7'h0, 1'b1);
    send(64'h9, 1'b1);
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("perr_total", 64'(err_seen), 64'(err_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
